// File: rtl/cdb_result_fifo.sv
// Result buffer between the functional-unit broadcast ports and the common data bus.
// Optional same-cycle bypass of port 0 onto an empty CDB is enabled by defining CDB_BYPASS_EN.
module cdb_result_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr0_en,
    input  logic [TAG_W-1:0]           wr0_tag,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [TAG_W-1:0]           wr1_tag,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       cdb_ready,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic                       fu_stall,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TAG_W-1:0] IDLE_TAG = '1;

    logic [TAG_W-1:0]  tagMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [CW-1:0]     countQ;
    logic              overflowQ;

    logic              qual0;
    logic              qual1;
    logic              fifoPop;
    logic [CW:0]       room;
    logic              acc0;
    logic              acc1;
    logic              store0;
    logic              store1;
    logic              dropAny;
    logic [1:0]        nStore;
    logic [PW-1:0]     wr1Addr;

    // Idle-tag pushes never qualify, so they neither occupy space nor count as drops.
    assign qual0   = wr0_en && (wr0_tag != IDLE_TAG);
    assign qual1   = wr1_en && (wr1_tag != IDLE_TAG);
    assign fifoPop = (countQ != '0) && cdb_ready;

    // A pop this cycle frees its slot for a push in the same cycle, so a full buffer can still accept.
    assign room = (CW+1)'(DEPTH) - {1'b0, countQ} + {{CW{1'b0}}, fifoPop};
    assign acc0 = qual0 && (room != '0);
    assign acc1 = qual1 && (acc0 ? (room >= (CW+1)'(2)) : (room != '0));
    assign dropAny = (qual0 && !acc0) || (qual1 && !acc1);

`ifdef CDB_BYPASS_EN
    logic bypassHit;
    assign bypassHit = (countQ == '0) && qual0;
    // A bypassed beat that the consumer takes immediately never needs a slot.
    assign store0 = acc0 && !(bypassHit && cdb_ready);
`else
    assign store0 = acc0;
`endif
    assign store1  = acc1;
    assign nStore  = {1'b0, store0} + {1'b0, store1};
    assign wr1Addr = wrPtr + PW'(store0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            countQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            wrPtr  <= wrPtr + PW'(nStore);
            rdPtr  <= rdPtr + PW'(fifoPop);
            countQ <= countQ + CW'(nStore) - CW'(fifoPop);
            if (dropAny) begin
                overflowQ <= 1'b1;
            end
        end
    end

    // Port 0 always lands ahead of port 1 so same-cycle arrivals keep their priority order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (store0) begin
                tagMem[wrPtr]  <= wr0_tag;
                dataMem[wrPtr] <= wr0_data;
            end
            if (store1) begin
                tagMem[wr1Addr]  <= wr1_tag;
                dataMem[wr1Addr] <= wr1_data;
            end
        end
    end

    always_comb begin
        cdb_valid = 1'b0;
        cdb_tag   = IDLE_TAG;
        cdb_data  = '0;
        if (countQ != '0) begin
            cdb_valid = 1'b1;
            cdb_tag   = tagMem[rdPtr];
            cdb_data  = dataMem[rdPtr];
        end
`ifdef CDB_BYPASS_EN
        else if (bypassHit) begin
            cdb_valid = 1'b1;
            cdb_tag   = wr0_tag;
            cdb_data  = wr0_data;
        end
`endif
    end

    assign fu_stall = countQ >= CW'(DEPTH - 2);
    assign count    = countQ;
    assign overflow = overflowQ;

endmodule

// File: tb/tb_cdb_result_fifo.sv
// Directed self-checking bench for cdb_result_fifo (default build, no bypass).
module tb_cdb_result_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr0_en;
    logic [3:0]  wr0_tag;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [3:0]  wr1_tag;
    logic [31:0] wr1_data;
    logic        cdb_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        fu_stall;
    logic [3:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    cdb_result_fifo #(.DEPTH(8), .DATA_W(32), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_tag(wr0_tag), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_tag(wr1_tag), .wr1_data(wr1_data),
        .cdb_ready(cdb_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .fu_stall(fu_stall), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        wr0_en = 1'b0; wr0_tag = 4'hF; wr0_data = '0;
        wr1_en = 1'b0; wr1_tag = 4'hF; wr1_data = '0;
    endtask

    task automatic applyStimulus(input logic e0, input logic [3:0] t0, input logic [31:0] d0,
                                 input logic e1, input logic [3:0] t1, input logic [31:0] d1);
        wr0_en = e0; wr0_tag = t0; wr0_data = d0;
        wr1_en = e1; wr1_tag = t1; wr1_data = d1;
        step();
        idleInputs();
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [3:0] expTags [8];
    logic [3:0] modelQ [$];
    logic       popNow;

    initial begin
        idleInputs();
        cdb_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Test 1: reset state after idling
        repeat (5) step();
        checkOutput("rst_valid", 64'(cdb_valid), 64'd0);
        checkOutput("rst_tag", 64'(cdb_tag), 64'hF);
        checkOutput("rst_data", 64'(cdb_data), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        checkOutput("rst_stall", 64'(fu_stall), 64'd0);

        // Test 2: single push, one-cycle latency
        cdb_ready = 1'b1;
        applyStimulus(1'b1, 4'd3, 32'h10, 1'b0, 4'hF, 32'h0);
        checkOutput("t2_valid", 64'(cdb_valid), 64'd1);
        checkOutput("t2_tag", 64'(cdb_tag), 64'd3);
        checkOutput("t2_data", 64'(cdb_data), 64'h10);
        checkOutput("t2_count", 64'(count), 64'd1);
        step();
        checkOutput("t2_empty", 64'(cdb_valid), 64'd0);
        checkOutput("t2_cnt0", 64'(count), 64'd0);

        // Test 3: dual push keeps port0 ahead, held under backpressure
        cdb_ready = 1'b0;
        applyStimulus(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
        checkOutput("t3_count", 64'(count), 64'd2);
        checkOutput("t3_hold1", 64'(cdb_tag), 64'd1);
        step();
        checkOutput("t3_hold2", 64'(cdb_tag), 64'd1);
        checkOutput("t3_hdata", 64'(cdb_data), 64'hA);
        cdb_ready = 1'b1;
        step();
        checkOutput("t3_tag2", 64'(cdb_tag), 64'd2);
        checkOutput("t3_data2", 64'(cdb_data), 64'hB);
        step();
        checkOutput("t3_empty", 64'(cdb_valid), 64'd0);

        // Test 4: fill, stall threshold, overflow, push+pop at full
        cdb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'hF, 32'h0);
            checkOutput($sformatf("t4_cnt%0d", i), 64'(count), 64'(i + 1));
            checkOutput($sformatf("t4_stall%0d", i), 64'(fu_stall), 64'((i + 1) >= 6));
        end
        checkOutput("t4_noovf", 64'(overflow), 64'd0);
        applyStimulus(1'b1, 4'd9, 32'h999, 1'b0, 4'hF, 32'h0);
        checkOutput("t4_fullcnt", 64'(count), 64'd8);
        checkOutput("t4_ovf", 64'(overflow), 64'd1);
        cdb_ready = 1'b1;
        applyStimulus(1'b1, 4'd10, 32'hAAA, 1'b0, 4'hF, 32'h0);
        checkOutput("t4_pp_cnt", 64'(count), 64'd8);
        expTags = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("t4_drain%0d", k), 64'(cdb_tag), 64'(expTags[k]));
            step();
        end
        checkOutput("t4_lastdata", 64'(cdb_valid), 64'd0);
        checkOutput("t4_stall_off", 64'(fu_stall), 64'd0);

        // Test 5: idle-tag pushes ignored
        doReset();
        applyStimulus(1'b1, 4'hF, 32'h55, 1'b1, 4'hF, 32'h66);
        checkOutput("t5_count", 64'(count), 64'd0);
        checkOutput("t5_ovf", 64'(overflow), 64'd0);
        checkOutput("t5_valid", 64'(cdb_valid), 64'd0);

        // Test 5b: room for one with both ports pushing keeps port0 only
        cdb_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 4'(i), 32'(i), 1'b0, 4'hF, 32'h0);
        end
        applyStimulus(1'b1, 4'd11, 32'hB11, 1'b1, 4'd12, 32'hC12);
        checkOutput("t5b_count", 64'(count), 64'd8);
        checkOutput("t5b_ovf", 64'(overflow), 64'd1);
        cdb_ready = 1'b1;
        for (int k = 0; k < 7; k++) step();
        checkOutput("t5b_last", 64'(cdb_tag), 64'd11);
        checkOutput("t5b_ldata", 64'(cdb_data), 64'hB11);
        step();
        checkOutput("t5b_empty", 64'(cdb_valid), 64'd0);

        // Test 6: reset mid-drain, then traffic across pointer wrap
        doReset();
        cdb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 32'(i), 1'b0, 4'hF, 32'h0);
        end
        cdb_ready = 1'b1;
        step();
        reset = 1'b1;
        step();
        checkOutput("t6_rvalid", 64'(cdb_valid), 64'd0);
        checkOutput("t6_rcount", 64'(count), 64'd0);
        reset = 1'b0;
        modelQ.delete();
        for (int j = 0; j < 20; j++) begin
            cdb_ready = (j % 3) != 2;
            popNow = (modelQ.size() != 0) && cdb_ready;
            if (modelQ.size() != 0) begin
                checkOutput($sformatf("t6_head%0d", j), 64'(cdb_tag), 64'(modelQ[0]));
            end
            wr0_en = 1'b1; wr0_tag = 4'(j % 15); wr0_data = 32'h200 + 32'(j);
            step();
            if (popNow) void'(modelQ.pop_front());
            modelQ.push_back(4'(j % 15));
            checkOutput($sformatf("t6_cnt%0d", j), 64'(count), 64'(modelQ.size()));
        end
        idleInputs();
        cdb_ready = 1'b1;
        while (modelQ.size() != 0) begin
            checkOutput("t6_drain", 64'(cdb_tag), 64'(modelQ[0]));
            void'(modelQ.pop_front());
            step();
        end
        checkOutput("t6_end", 64'(cdb_valid), 64'd0);
        checkOutput("t6_ovf", 64'(overflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
